ballot_controller: RTL and testbench

//  Voting-side sequencer for the EVM. Arms one ballot per presiding-officer enable, synchronises and

---
 rtl/ballot_controller_if.sv | 26 ++
 rtl/ballot_controller.sv | 133 +++++++++++++
 tb/tb_ballot_controller.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ballot_controller_if.sv
// Signal bundle between the ballot unit / officer console and the ballot_controller.
// The master side drives mode, enable and the raw buttons; the slave side returns tallies and status.
interface ballot_controller_if #(
  parameter int NUM_CAND = 6,
  parameter int VOTE_W   = 8
);
  logic                       mode;
  logic                       ballot_enable;
  logic [NUM_CAND-1:0]        cand_button;
  logic                       valid_vote_casted;
  logic [NUM_CAND*VOTE_W-1:0] cand_vote;
  logic                       armed;
  logic                       busy;
  logic                       conflict_err;
  logic                       sat_flag;

  modport master (
    output mode, ballot_enable, cand_button,
    input  valid_vote_casted, cand_vote, armed, busy, conflict_err, sat_flag
  );

  modport slave (
    input  mode, ballot_enable, cand_button,
    output valid_vote_casted, cand_vote, armed, busy, conflict_err, sat_flag
  );
endinterface

// File: rtl/ballot_controller.sv
// Voting-side sequencer: arms one ballot per officer enable, qualifies a single stable
// candidate press, records it in a saturating tally and locks out until the hold window ends.
module ballot_controller #(
  parameter int NUM_CAND      = 6,
  parameter int VOTE_W        = 8,
  parameter int STABLE_CYCLES = 1000000,
  parameter int HOLD_CYCLES   = 100000000
) (
  input logic               clock,
  input logic               reset,
  ballot_controller_if.slave bus
);

  localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam logic [VOTE_W-1:0] TALLY_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, CAST, HOLD} state_t;

  state_t              state_q, state_d;
  logic [NUM_CAND-1:0] sync1_q, btn_s, btn_prev_q;
  logic [CNT_W-1:0]    sc_q, sc_d, hc_q, hc_d;
  logic [IDX_W-1:0]    cand_idx_q, cand_idx_d, btn_idx;
  logic [VOTE_W-1:0]   tally_q [NUM_CAND];
  logic                valid_q, armed_q, busy_q, conflict_q, sat_q;
  logic                one_hot, multi;

  assign one_hot = ($countones(btn_s) == 1);
  assign multi   = ($countones(btn_s) > 1);

  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < NUM_CAND; i++)
      if (btn_s[i]) btn_idx = IDX_W'(i);
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    hc_d       = hc_q;
    cand_idx_d = cand_idx_q;
    unique case (state_q)
      IDLE: begin
        sc_d = '0;
        hc_d = '0;
        if (bus.ballot_enable && !bus.mode) state_d = ARMED;
      end
      ARMED: begin
        if (bus.mode) begin
          state_d = IDLE;
          sc_d    = '0;
        end else if (one_hot && (btn_s == btn_prev_q)) begin
          if (sc_q == CNT_W'(STABLE_CYCLES - 1)) begin
            state_d    = CAST;
            cand_idx_d = btn_idx;
            sc_d       = '0;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end else begin
          sc_d = '0;
        end
      end
      CAST: begin
        state_d = HOLD;
        hc_d    = '0;
      end
      HOLD: begin
        // hc parks at its terminal count until every button is released.
        if (hc_q == CNT_W'(HOLD_CYCLES - 1)) begin
          if (btn_s == '0) state_d = IDLE;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      btn_s      <= '0;
      btn_prev_q <= '0;
      sc_q       <= '0;
      hc_q       <= '0;
      cand_idx_q <= '0;
      valid_q    <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= bus.cand_button;
      btn_s      <= sync1_q;
      btn_prev_q <= btn_s;
      sc_q       <= sc_d;
      hc_q       <= hc_d;
      cand_idx_q <= cand_idx_d;
      valid_q    <= (state_d == CAST);
      armed_q    <= (state_d == ARMED);
      busy_q     <= (state_d == CAST) || (state_d == HOLD);
      conflict_q <= (state_d == ARMED) && multi;
    end
  end

  // NOTE: the tally array is architectural state that must read zero after reset, so it is reset
  // flop by flop rather than being treated as an uninitialised RAM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      sat_q <= 1'b0;
    end else if (state_q == CAST) begin
      if (tally_q[cand_idx_q] == TALLY_MAX) sat_q <= 1'b1;
      else tally_q[cand_idx_q] <= tally_q[cand_idx_q] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_tally_out
    assign bus.cand_vote[g*VOTE_W +: VOTE_W] = tally_q[g];
  end

  assign bus.valid_vote_casted = valid_q;
  assign bus.armed             = armed_q;
  assign bus.busy              = busy_q;
  assign bus.conflict_err      = conflict_q;
  assign bus.sat_flag          = sat_q;

endmodule

// File: tb/tb_ballot_controller.sv
// Scoreboard bench for ballot_controller: stimulus predicts each recorded vote from the ballot
// rules and queues it; an independent monitor checks pulse timing, tallies, sat_flag and lockout.
module tb_ballot_controller;
  localparam int NUM_CAND = 6;
  localparam int VOTE_W   = 8;
  localparam int STABLE   = 4;
  localparam int HOLD     = 10;
  localparam int LAT      = 2 + STABLE + 1;
  localparam int TMAX     = (1 << VOTE_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ballot_controller_if #(.NUM_CAND(NUM_CAND), .VOTE_W(VOTE_W)) bus ();

  ballot_controller #(
    .NUM_CAND(NUM_CAND), .VOTE_W(VOTE_W), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [NUM_CAND*VOTE_W-1:0] tallies;
    logic                       sat;
    int                         at_cyc;
    int                         busy_len;
  } exp_t;

  exp_t exp_q[$];
  int   model[NUM_CAND];
  bit   model_sat;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [NUM_CAND*VOTE_W-1:0] model_vector();
    logic [NUM_CAND*VOTE_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CAND; i++) r[i*VOTE_W +: VOTE_W] = VOTE_W'(model[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called when the raw buttons take their final one-hot value and will be held for len cycles.
  task automatic push_vote(input int c, input int len);
    exp_t e;
    if (model[c] == TMAX) model_sat = 1'b1;
    else model[c]++;
    e.tallies  = model_vector();
    e.sat      = model_sat;
    e.at_cyc   = cyc + LAT;
    e.busy_len = (len - STABLE > HOLD + 1) ? len - STABLE : HOLD + 1;
    exp_q.push_back(e);
  endtask

  task automatic arm_ballot();
    bus.ballot_enable = 1'b1;
    tick();
    bus.ballot_enable = 1'b0;
    check("armed_after_enable", bus.armed, 1);
  endtask

  task automatic hold_btn(input logic [NUM_CAND-1:0] v, input int len);
    bus.cand_button = v;
    repeat (len) tick();
    bus.cand_button = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.armed || bus.busy) && n < 200) begin
      tick();
      n++;
    end
    check("return_to_idle", {bus.armed, bus.busy}, 0);
    tick();
  endtask

  function automatic logic [NUM_CAND-1:0] onehot(input int c);
    return NUM_CAND'(1) << c;
  endfunction

  task automatic clean_vote(input int c, input int len);
    arm_ballot();
    push_vote(c, len);
    hold_btn(onehot(c), len);
    wait_idle();
  endtask

  task automatic bounce_vote(input int c, input int b, input int gap, input int len);
    arm_ballot();
    hold_btn(onehot(c), b);
    repeat (gap) tick();
    check("bounce_still_armed", bus.armed, 1);
    push_vote(c, len);
    hold_btn(onehot(c), len);
    wait_idle();
  endtask

  task automatic conflict_vote(input int c1, input int c2, input int len);
    arm_ballot();
    bus.cand_button = onehot(c1) | onehot(c2);
    repeat (4) tick();
    check("conflict_set", bus.conflict_err, 1);
    check("conflict_still_armed", bus.armed, 1);
    push_vote(c1, len);
    bus.cand_button = onehot(c1);
    repeat (len) tick();
    check("conflict_clear", bus.conflict_err, 0);
    bus.cand_button = '0;
    wait_idle();
  endtask

  task automatic abort_ballot(input int c, input int k);
    arm_ballot();
    bus.cand_button = onehot(c);
    repeat (k) tick();
    bus.mode = 1'b1;
    tick();
    check("abort_armed", bus.armed, 0);
    check("abort_busy", bus.busy, 0);
    bus.cand_button = '0;
    bus.ballot_enable = 1'b1;
    tick();
    bus.ballot_enable = 1'b0;
    check("enable_in_result_mode", bus.armed, 0);
    repeat (3) tick();
    bus.mode = 1'b0;
    tick();
  endtask

  task automatic unarmed_press(input int c);
    hold_btn(onehot(c), 12);
    check("unarmed_armed", bus.armed, 0);
    check("unarmed_busy", bus.busy, 0);
    repeat (3) tick();
  endtask

  // Monitor: pops a prediction on each valid pulse, then checks tallies and lockout length.
  initial begin : monitor
    exp_t cur;
    bit   pend, in_run;
    int   run;
    pend = 0; in_run = 0; run = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        pend = 0; in_run = 0; run = 0;
      end else begin
        if (pend) begin
          check("tallies", bus.cand_vote, cur.tallies);
          check("sat_flag", bus.sat_flag, cur.sat);
          check("pulse_width", bus.valid_vote_casted, 0);
          pend = 0;
        end else if (bus.valid_vote_casted) begin
          check("vote_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("pulse_cycle", cyc, cur.at_cyc);
            pend = 1; in_run = 1; run = 0;
          end
        end
        if (in_run) begin
          if (bus.busy) run++;
          else begin
            check("busy_len", run, cur.busy_len);
            in_run = 0;
          end
        end
      end
    end
  end

  task automatic apply_reset_and_check(input string tag);
    reset = 1'b0;
    @(negedge clock);
    check({tag, "_tallies"}, bus.cand_vote, 0);
    check({tag, "_outputs"}, {bus.valid_vote_casted, bus.armed, bus.busy,
                              bus.conflict_err, bus.sat_flag}, 0);
    for (int i = 0; i < NUM_CAND; i++) model[i] = 0;
    model_sat = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    bus.mode          = 1'b0;
    bus.ballot_enable = 1'b0;
    bus.cand_button   = '0;
    for (int i = 0; i < NUM_CAND; i++) model[i] = 0;
    model_sat = 1'b0;
    repeat (3) tick();
    apply_reset_and_check("por");

    // Reset mid-HOLD with candidate 3 at 5 votes.
    for (int v = 0; v < 4; v++) clean_vote(2, 6);
    arm_ballot();
    push_vote(2, 6);
    hold_btn(onehot(2), 6);
    n = 0;
    while (!bus.busy && n < 20) begin tick(); n++; end
    check("reached_cast", bus.busy, 1);
    repeat (4) tick();
    check("mid_hold_busy", bus.busy, 1);
    apply_reset_and_check("mid_hold");

    clean_vote(1, 8);          // nominal vote, 11-cycle lockout
    conflict_vote(0, 3, 6);    // two buttons, then release one
    bounce_vote(4, 3, 2, 6);   // short bounce then a good press
    abort_ballot(3, 2);        // mode flip before qualification
    unarmed_press(5);          // press without an enable
    clean_vote(2, 5);          // minimum qualifying hold
    clean_vote(0, 20);         // button held past the hold window

    for (int it = 0; it < 40; it++) begin
      int c, c2, kind;
      c    = $urandom_range(NUM_CAND - 1);
      kind = $urandom_range(4);
      case (kind)
        0: clean_vote(c, $urandom_range(20, 5));
        1: bounce_vote(c, $urandom_range(3, 1), $urandom_range(3, 1), $urandom_range(12, 5));
        2: begin
          c2 = (c + 1 + $urandom_range(NUM_CAND - 2)) % NUM_CAND;
          conflict_vote(c, c2, $urandom_range(12, 5));
        end
        3: abort_ballot(c, $urandom_range(3, 1));
        default: unarmed_press(c);
      endcase
      repeat ($urandom_range(3)) tick();
    end

    // Drive candidate 6 to saturation, overflow once, then confirm sat_flag stays set.
    while (model[5] < TMAX) clean_vote(5, 5);
    check("sat_before_overflow", bus.sat_flag, 0);
    clean_vote(5, 5);
    clean_vote(0, 6);
    check("sat_sticky", bus.sat_flag, 1);

    repeat (5) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
